// File: rtl/mmio_bus_fabric_if.sv
// Bus bundle between the RV32 data port, mmio_bus_fabric and its NUM_SLV peripherals.
interface mmio_bus_fabric_if #(
  parameter int NUM_SLV = 8
);
  // CPU side: a request is an rstrb pulse or a nonzero wstrb while the fabric is idle
  // (busy=0 and no done this cycle); the answer is the single-cycle done pulse with
  // rdata valid. Slave side: exactly one s_rstrb/s_wstrb pulse per transaction, and
  // the slave completes by raising s_ready with s_rdata valid in the same cycle.
  logic [31:0]            addr;
  logic [31:0]            wdata;
  logic [3:0]             wstrb;
  logic                   rstrb;
  logic [31:0]            rdata;
  logic                   busy;
  logic                   done;
  logic [NUM_SLV-1:0]     s_rstrb;
  logic [4*NUM_SLV-1:0]   s_wstrb;
  logic [31:0]            s_addr;
  logic [31:0]            s_wdata;
  logic [32*NUM_SLV-1:0]  s_rdata;
  logic [NUM_SLV-1:0]     s_ready;
  logic [1:0]             fsm_state;

  modport master (
    output addr, wdata, wstrb, rstrb, s_rdata, s_ready,
    input  rdata, busy, done, s_rstrb, s_wstrb, s_addr, s_wdata, fsm_state
  );

  modport slave (
    input  addr, wdata, wstrb, rstrb, s_rdata, s_ready,
    output rdata, busy, done, s_rstrb, s_wstrb, s_addr, s_wdata, fsm_state
  );
endinterface

// File: rtl/mmio_bus_fabric.sv
// Table-decoded MMIO interconnect with registered handshake, timeout and error window.
// Optional MMIO_BUS_ERR_IRQ_EN adds err_irq and an irq enable bit at fabric offset 0x8.
module mmio_bus_fabric #(
  parameter int                    NUM_SLV     = 8,
  parameter logic [16*NUM_SLV-1:0] SLV_BASE    = {16'h0600, 16'h0500, 16'h4000, 16'h3000,
                                                  16'h2000, 16'h1000, 16'hA000, 16'h0000},
  parameter logic [15:0]           FAB_BASE    = 16'hF000,
  parameter int                    TIMEOUT_CYC = 64,
  parameter logic [31:0]           ERR_DATA    = 32'hDEADBEEF
) (
  input  logic             clk,
  input  logic             rst,
  mmio_bus_fabric_if.slave bus
`ifdef MMIO_BUS_ERR_IRQ_EN
  ,
  output logic             err_irq
`endif
);
  localparam int IW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t               state_q, state_d;
  logic                 req, req_write, fab_hit, slv_hit;
  logic [IW-1:0]        hit_idx, sel_q;
  logic                 write_q, sel_ready;
  logic [31:0]          sel_rdata, fab_rdata, resp_val;
  logic [31:0]          addr_q, wdata_q, rdata_q;
  logic                 busy_q, done_q;
  logic [NUM_SLV-1:0]   s_rstrb_q;
  logic [4*NUM_SLV-1:0] s_wstrb_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 timeout_hit, start_issue, load_resp;
  logic                 err_set, fab_clear;
  logic [1:0]           err_cause_new;
  logic [31:0]          err_addr_new;
  logic                 err_sticky_q;
  logic [1:0]           err_cause_q;
  logic [31:0]          err_addr_q;
`ifdef MMIO_BUS_ERR_IRQ_EN
  logic                 irq_en_q, irq_en_wr;
`endif

  assign req       = (state_q == IDLE) && (bus.rstrb || (bus.wstrb != 4'h0));
  assign req_write = (bus.wstrb != 4'h0);
  assign fab_hit   = (bus.addr[31:16] == FAB_BASE);

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    slv_hit = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if (bus.addr[31:16] == SLV_BASE[16*i +: 16]) begin
        slv_hit = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  assign sel_ready   = bus.s_ready[sel_q];
  assign sel_rdata   = bus.s_rdata[32*int'(sel_q) +: 32];
  assign timeout_hit = (TIMEOUT_CYC != 0) && ((int'(cnt_q) + 1) >= TIMEOUT_CYC);

  always_comb begin
    fab_rdata = 32'h0;
    case (bus.addr[15:0])
      16'h0000: fab_rdata = {29'b0, err_cause_q, err_sticky_q};
      16'h0004: fab_rdata = err_addr_q;
`ifdef MMIO_BUS_ERR_IRQ_EN
      16'h0008: fab_rdata = {31'b0, irq_en_q};
`endif
      default:  fab_rdata = 32'h0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    start_issue   = 1'b0;
    load_resp     = 1'b0;
    resp_val      = 32'h0;
    err_set       = 1'b0;
    err_cause_new = 2'd0;
    err_addr_new  = 32'h0;
    fab_clear     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (fab_hit) begin
            state_d   = RESP;
            load_resp = 1'b1;
            resp_val  = req_write ? 32'h0 : fab_rdata;
            fab_clear = req_write && (bus.addr[15:0] == 16'h0000) && bus.wdata[0];
          end else if (slv_hit) begin
            state_d     = ISSUE;
            start_issue = 1'b1;
            cnt_d       = '0;
          end else begin
            state_d       = RESP;
            load_resp     = 1'b1;
            resp_val      = ERR_DATA;
            err_set       = 1'b1;
            err_cause_new = 2'd1;
            err_addr_new  = bus.addr;
          end
        end
      end
      ISSUE: begin
        if (sel_ready) begin
          state_d   = RESP;
          load_resp = 1'b1;
          resp_val  = write_q ? 32'h0 : sel_rdata;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (sel_ready) begin
          state_d   = RESP;
          load_resp = 1'b1;
          resp_val  = write_q ? 32'h0 : sel_rdata;
        end else begin
          if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + 1'b1;
          if (timeout_hit) begin
            state_d       = RESP;
            load_resp     = 1'b1;
            resp_val      = ERR_DATA;
            err_set       = 1'b1;
            err_cause_new = 2'd2;
            err_addr_new  = addr_q;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Slave strobes are loaded on the accept edge and cleared on the next, so they
  // are high for the single ISSUE cycle only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      rdata_q      <= 32'h0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      s_rstrb_q    <= '0;
      s_wstrb_q    <= '0;
      cnt_q        <= '0;
      err_sticky_q <= 1'b0;
      err_cause_q  <= 2'd0;
      err_addr_q   <= 32'h0;
    end else begin
      cnt_q     <= cnt_d;
      busy_q    <= (state_d == ISSUE) || (state_d == WAIT);
      done_q    <= (state_d == RESP);
      s_rstrb_q <= '0;
      s_wstrb_q <= '0;
      if (start_issue) begin
        sel_q   <= hit_idx;
        write_q <= req_write;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        if (req_write) s_wstrb_q[4*int'(hit_idx) +: 4] <= bus.wstrb;
        else           s_rstrb_q[hit_idx] <= 1'b1;
      end
      if (load_resp) rdata_q <= resp_val;
      if (err_set) begin
        err_sticky_q <= 1'b1;
        err_cause_q  <= err_cause_new;
        err_addr_q   <= err_addr_new;
      end else if (fab_clear) begin
        err_sticky_q <= 1'b0;
        err_cause_q  <= 2'd0;
        err_addr_q   <= 32'h0;
      end
    end
  end

`ifdef MMIO_BUS_ERR_IRQ_EN
  assign irq_en_wr = req && req_write && fab_hit && (bus.addr[15:0] == 16'h0008);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en_q <= 1'b0;
      err_irq  <= 1'b0;
    end else begin
      if (irq_en_wr) irq_en_q <= bus.wdata[0];
      err_irq <= err_sticky_q & irq_en_q;
    end
  end
`endif

  assign bus.rdata     = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.s_rstrb   = s_rstrb_q;
  assign bus.s_wstrb   = s_wstrb_q;
  assign bus.s_addr    = addr_q;
  assign bus.s_wdata   = wdata_q;
  assign bus.fsm_state = state_q;
endmodule

// File: tb/tb_mmio_bus_fabric.sv
// Randomized self-checking bench for mmio_bus_fabric against an address-table reference model.
`timescale 1ns/1ps
module tb_mmio_bus_fabric;
  localparam int          NS  = 8;
  localparam int          TO  = 64;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mmio_bus_fabric_if #(.NUM_SLV(NS)) bus ();
`ifdef MMIO_BUS_ERR_IRQ_EN
  logic err_irq;
`endif

  mmio_bus_fabric #(.NUM_SLV(NS), .TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MMIO_BUS_ERR_IRQ_EN
    ,
    .err_irq (err_irq)
`endif
  );

  typedef struct {
    int              lat;
    logic [31:0]     rd;
    logic [NS-1:0]   rs;
    logic [4*NS-1:0] ws;
    int              strobes;
    int              busy_n;
    logic [31:0]     sa;
    logic [31:0]     swd;
  } obs_t;

  int          check_cnt = 0;
  int          fail_cnt  = 0;
  obs_t        obs;
  logic [15:0] base_tab [NS];
  logic [31:0] slv_data [NS];
  logic        m_sticky = 1'b0;
  logic [1:0]  m_cause  = 2'd0;
  logic [31:0] m_addr   = 32'h0;
  logic        m_irq_en = 1'b0;

  // ---------------- reference model ----------------
  function automatic int ref_target(input logic [31:0] a);
    if (a[31:16] == 16'hF000) return -2;
    for (int i = 0; i < NS; i++) if (a[31:16] == base_tab[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] ref_fab_read(input logic [15:0] off);
    if (off == 16'h0000) return {29'b0, m_cause, m_sticky};
    if (off == 16'h0004) return m_addr;
`ifdef MMIO_BUS_ERR_IRQ_EN
    if (off == 16'h0008) return {31'b0, m_irq_en};
`endif
    return 32'h0;
  endfunction

  task automatic model_error(input logic [1:0] cause, input logic [31:0] a);
    m_sticky = 1'b1;
    m_cause  = cause;
    m_addr   = a;
  endtask

  task automatic model_clear();
    m_sticky = 1'b0;
    m_cause  = 2'd0;
    m_addr   = 32'h0;
  endtask

  // ---------------- drivers ----------------
  task automatic drive_idle();
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;
    bus.wstrb = 4'h0;
    bus.rstrb = 1'b0;
  endtask

  task automatic load_slave_data();
    for (int i = 0; i < NS; i++) begin
      slv_data[i] = $urandom;
      bus.s_rdata[32*i +: 32] = slv_data[i];
    end
  endtask

  // One CPU transaction; the target slave's s_ready rises at cycle rdy_at (-1: never).
  task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     input logic rs, input int tgt, input int rdy_at, input logic [NS-1:0] noise);
    @(negedge clk);
    bus.addr  = a;
    bus.wdata = wd;
    bus.wstrb = ws;
    bus.rstrb = rs;
    bus.s_ready = noise;
    if (tgt >= 0) bus.s_ready[tgt] = (rdy_at == 0);
    obs.lat = -1; obs.rd = 32'h0; obs.rs = '0; obs.ws = '0;
    obs.strobes = 0; obs.busy_n = 0; obs.sa = 32'h0; obs.swd = 32'h0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) drive_idle();
      if (bus.busy) obs.busy_n++;
      if ((bus.s_rstrb != '0) || (bus.s_wstrb != '0)) begin
        obs.strobes++;
        obs.rs  = obs.rs | bus.s_rstrb;
        obs.ws  = obs.ws | bus.s_wstrb;
        obs.sa  = bus.s_addr;
        obs.swd = bus.s_wdata;
      end
      if (bus.done) begin
        obs.lat = c;
        obs.rd  = bus.rdata;
        break;
      end
      if (tgt >= 0 && c == rdy_at) bus.s_ready[tgt] = 1'b1;
    end
    bus.s_ready = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    check_cnt++; if (bus.busy !== 1'b0) begin fail_cnt++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    check_cnt++; if (bus.done !== 1'b0) begin fail_cnt++; $display("FAIL rst_done: got %b expected 0", bus.done); end
    check_cnt++; if (bus.rdata !== 32'h0) begin fail_cnt++; $display("FAIL rst_rdata: got %h expected 0", bus.rdata); end
    check_cnt++; if (bus.s_rstrb !== '0) begin fail_cnt++; $display("FAIL rst_s_rstrb: got %b expected 0", bus.s_rstrb); end
    check_cnt++; if (bus.s_wstrb !== '0) begin fail_cnt++; $display("FAIL rst_s_wstrb: got %h expected 0", bus.s_wstrb); end
    check_cnt++; if (bus.s_addr !== 32'h0) begin fail_cnt++; $display("FAIL rst_s_addr: got %h expected 0", bus.s_addr); end
    check_cnt++; if (bus.s_wdata !== 32'h0) begin fail_cnt++; $display("FAIL rst_s_wdata: got %h expected 0", bus.s_wdata); end
    check_cnt++; if (bus.fsm_state !== 2'd0) begin fail_cnt++; $display("FAIL rst_state: got %0d expected 0", bus.fsm_state); end
    rst = 1'b0;
    txn(32'hF000_0000, 32'h0, 4'h0, 1'b1, -1, -1, '0);
    check_cnt++; if (obs.rd !== 32'h0) begin fail_cnt++; $display("FAIL rst_status: got %h expected 0", obs.rd); end
    check_cnt++; if (obs.lat !== 1) begin fail_cnt++; $display("FAIL rst_fab_lat: got %0d expected 1", obs.lat); end
  endtask

  task automatic test_read_zero_wait();
    slv_data[3] = 32'h0000_00A5;
    bus.s_rdata[32*3 +: 32] = slv_data[3];
    txn(32'h2000_0004, 32'h0, 4'h0, 1'b1, 3, 0, '0);
    check_cnt++; if (obs.rs !== 8'b0000_1000) begin fail_cnt++; $display("FAIL rd_strobe: got %b expected 00001000", obs.rs); end
    check_cnt++; if (obs.strobes !== 1) begin fail_cnt++; $display("FAIL rd_strobe_cnt: got %0d expected 1", obs.strobes); end
    check_cnt++; if (obs.lat !== 2) begin fail_cnt++; $display("FAIL rd_lat: got %0d expected 2", obs.lat); end
    check_cnt++; if (obs.rd !== 32'h0000_00A5) begin fail_cnt++; $display("FAIL rd_data: got %h expected 000000a5", obs.rd); end
    check_cnt++; if (obs.busy_n !== 1) begin fail_cnt++; $display("FAIL rd_busy_cycles: got %0d expected 1", obs.busy_n); end
    check_cnt++; if (obs.sa !== 32'h2000_0004) begin fail_cnt++; $display("FAIL rd_s_addr: got %h expected 20000004", obs.sa); end
  endtask

  task automatic test_write();
    txn(32'h1000_0008, 32'h1234_5678, 4'b0011, 1'b0, 2, 0, '0);
    check_cnt++; if (obs.ws !== 32'h0000_0300) begin fail_cnt++; $display("FAIL wr_strobe: got %h expected 00000300", obs.ws); end
    check_cnt++; if (obs.rs !== '0) begin fail_cnt++; $display("FAIL wr_rstrb: got %b expected 0", obs.rs); end
    check_cnt++; if (obs.strobes !== 1) begin fail_cnt++; $display("FAIL wr_strobe_cnt: got %0d expected 1", obs.strobes); end
    check_cnt++; if (obs.swd !== 32'h1234_5678) begin fail_cnt++; $display("FAIL wr_s_wdata: got %h expected 12345678", obs.swd); end
    check_cnt++; if (obs.lat !== 2) begin fail_cnt++; $display("FAIL wr_lat: got %0d expected 2", obs.lat); end
    check_cnt++; if (obs.rd !== 32'h0) begin fail_cnt++; $display("FAIL wr_rdata: got %h expected 0", obs.rd); end
  endtask

  task automatic test_unmapped();
    txn(32'h7777_0000, 32'h0, 4'h0, 1'b1, -1, -1, '0);
    model_error(2'd1, 32'h7777_0000);
    check_cnt++; if (obs.lat !== 1) begin fail_cnt++; $display("FAIL um_lat: got %0d expected 1", obs.lat); end
    check_cnt++; if (obs.rd !== ERR) begin fail_cnt++; $display("FAIL um_rdata: got %h expected %h", obs.rd, ERR); end
    check_cnt++; if (obs.strobes !== 0) begin fail_cnt++; $display("FAIL um_strobes: got %0d expected 0", obs.strobes); end
    check_cnt++; if (obs.busy_n !== 0) begin fail_cnt++; $display("FAIL um_busy: got %0d expected 0", obs.busy_n); end
    txn(32'hF000_0000, 32'h0, 4'h0, 1'b1, -1, -1, '0);
    check_cnt++; if (obs.rd !== 32'h3) begin fail_cnt++; $display("FAIL um_status: got %h expected 3", obs.rd); end
    txn(32'hF000_0004, 32'h0, 4'h0, 1'b1, -1, -1, '0);
    check_cnt++; if (obs.rd !== 32'h7777_0000) begin fail_cnt++; $display("FAIL um_err_addr: got %h expected 77770000", obs.rd); end
  endtask

  task automatic test_timeout();
    txn(32'h4000_0010, 32'h0, 4'h0, 1'b1, 5, -1, '0);
    model_error(2'd2, 32'h4000_0010);
    check_cnt++; if (obs.lat !== TO + 2) begin fail_cnt++; $display("FAIL to_lat: got %0d expected %0d", obs.lat, TO + 2); end
    check_cnt++; if (obs.rd !== ERR) begin fail_cnt++; $display("FAIL to_rdata: got %h expected %h", obs.rd, ERR); end
    check_cnt++; if (obs.rs !== 8'b0010_0000) begin fail_cnt++; $display("FAIL to_strobe: got %b expected 00100000", obs.rs); end
    txn(32'hF000_0000, 32'h0, 4'h0, 1'b1, -1, -1, '0);
    check_cnt++; if (obs.rd !== 32'h5) begin fail_cnt++; $display("FAIL to_status: got %h expected 5", obs.rd); end
    txn(32'hF000_0004, 32'h0, 4'h0, 1'b1, -1, -1, '0);
    check_cnt++; if (obs.rd !== 32'h4000_0010) begin fail_cnt++; $display("FAIL to_err_addr: got %h expected 40000010", obs.rd); end
    txn(32'hF000_0000, 32'h1, 4'hF, 1'b0, -1, -1, '0);
    model_clear();
    txn(32'hF000_0000, 32'h0, 4'h0, 1'b1, -1, -1, '0);
    check_cnt++; if (obs.rd !== 32'h0) begin fail_cnt++; $display("FAIL clr_status: got %h expected 0", obs.rd); end
    txn(32'hF000_0004, 32'h0, 4'h0, 1'b1, -1, -1, '0);
    check_cnt++; if (obs.rd !== 32'h0) begin fail_cnt++; $display("FAIL clr_err_addr: got %h expected 0", obs.rd); end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    int strobes = 0;
    @(negedge clk);
    bus.addr    = 32'h2000_0000;
    bus.rstrb   = 1'b1;
    bus.s_ready = 8'b0000_1000;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.done) dones++;
      if (bus.s_rstrb != '0) strobes++;
      if (c == 2) drive_idle();
    end
    bus.s_ready = '0;
    check_cnt++; if (dones !== 1) begin fail_cnt++; $display("FAIL b2b_dones: got %0d expected 1", dones); end
    check_cnt++; if (strobes !== 1) begin fail_cnt++; $display("FAIL b2b_strobes: got %0d expected 1", strobes); end
    txn(32'h2000_0000, 32'h0, 4'h0, 1'b1, 3, 0, '0);
    check_cnt++; if (obs.lat !== 2) begin fail_cnt++; $display("FAIL b2b_next_lat: got %0d expected 2", obs.lat); end
    check_cnt++; if (obs.rd !== slv_data[3]) begin fail_cnt++; $display("FAIL b2b_next_rdata: got %h expected %h", obs.rd, slv_data[3]); end
  endtask

  task automatic test_random();
    logic [31:0]     a, wd, exp_rd;
    logic [3:0]      ws;
    logic            rs, wr, ok;
    logic [NS-1:0]   noise, exp_rs;
    logic [4*NS-1:0] exp_ws;
    int              kind, tgt, r, eff, exp_lat, exp_strobes;
    load_slave_data();
    for (int n = 0; n < 40; n++) begin
      kind  = $urandom_range(0, 9);
      wr    = 1'($urandom_range(0, 1));
      ws    = wr ? 4'($urandom_range(1, 15)) : 4'h0;
      rs    = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      wd    = $urandom;
      noise = NS'($urandom);
      if (kind <= 5) a = {base_tab[$urandom_range(0, NS - 1)], 16'($urandom)};
      else if (kind <= 7) a = {16'h7000 + 16'($urandom_range(0, 255)), 16'($urandom)};
      else a = {16'hF000, 16'($urandom_range(0, 3) * 4)};
      tgt = ref_target(a);
      r   = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 6);
      if (tgt >= 0) noise[tgt] = 1'b0;
      exp_rs = '0;
      exp_ws = '0;
      exp_strobes = 0;
      if (tgt >= 0) begin
        eff         = (r < 1) ? 1 : r;
        ok          = (r >= 0) && (eff <= TO + 1);
        exp_lat     = ok ? eff + 1 : TO + 2;
        exp_rd      = !ok ? ERR : (wr ? 32'h0 : slv_data[tgt]);
        exp_strobes = 1;
        if (wr) exp_ws = {{(4*NS-4){1'b0}}, ws} << (4 * tgt);
        else    exp_rs = NS'(1) << tgt;
      end else if (tgt == -1) begin
        exp_lat = 1;
        exp_rd  = ERR;
      end else begin
        exp_lat = 1;
        exp_rd  = wr ? 32'h0 : ref_fab_read(a[15:0]);
      end
      txn(a, wd, ws, rs, tgt, r, noise);
      if (tgt >= 0 && !ok) model_error(2'd2, a);
      if (tgt == -1) model_error(2'd1, a);
      if (tgt == -2 && wr && a[15:0] == 16'h0000 && wd[0]) model_clear();
`ifdef MMIO_BUS_ERR_IRQ_EN
      if (tgt == -2 && wr && a[15:0] == 16'h0008) m_irq_en = wd[0];
`endif
      check_cnt++; if (obs.lat !== exp_lat) begin fail_cnt++; $display("FAIL rand%0d_lat: got %0d expected %0d", n, obs.lat, exp_lat); end
      check_cnt++; if (obs.rd !== exp_rd) begin fail_cnt++; $display("FAIL rand%0d_rdata: got %h expected %h", n, obs.rd, exp_rd); end
      check_cnt++; if (obs.strobes !== exp_strobes) begin fail_cnt++; $display("FAIL rand%0d_strobes: got %0d expected %0d", n, obs.strobes, exp_strobes); end
      check_cnt++; if (obs.rs !== exp_rs) begin fail_cnt++; $display("FAIL rand%0d_s_rstrb: got %b expected %b", n, obs.rs, exp_rs); end
      check_cnt++; if (obs.ws !== exp_ws) begin fail_cnt++; $display("FAIL rand%0d_s_wstrb: got %h expected %h", n, obs.ws, exp_ws); end
      if (tgt >= 0) begin
        check_cnt++; if (obs.sa !== a) begin fail_cnt++; $display("FAIL rand%0d_s_addr: got %h expected %h", n, obs.sa, a); end
      end
    end
    exp_rd = ref_fab_read(16'h0000);
    txn(32'hF000_0000, 32'h0, 4'h0, 1'b1, -1, -1, '0);
    check_cnt++; if (obs.rd !== exp_rd) begin fail_cnt++; $display("FAIL rand_status: got %h expected %h", obs.rd, exp_rd); end
    exp_rd = ref_fab_read(16'h0004);
    txn(32'hF000_0004, 32'h0, 4'h0, 1'b1, -1, -1, '0);
    check_cnt++; if (obs.rd !== exp_rd) begin fail_cnt++; $display("FAIL rand_err_addr: got %h expected %h", obs.rd, exp_rd); end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    int strobes = 0;
    txn(32'h7100_0040, 32'h0, 4'h0, 1'b1, -1, -1, '0);
    model_error(2'd1, 32'h7100_0040);
    @(negedge clk);
    bus.addr    = 32'h3000_0000;
    bus.rstrb   = 1'b1;
    bus.s_ready = '0;
    @(negedge clk);
    drive_idle();
    check_cnt++; if (bus.s_rstrb !== 8'b0001_0000) begin fail_cnt++; $display("FAIL mid_strobe: got %b expected 00010000", bus.s_rstrb); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    model_clear();
    check_cnt++; if (bus.busy !== 1'b0) begin fail_cnt++; $display("FAIL mid_busy: got %b expected 0", bus.busy); end
    check_cnt++; if (bus.done !== 1'b0) begin fail_cnt++; $display("FAIL mid_done: got %b expected 0", bus.done); end
    check_cnt++; if (bus.s_addr !== 32'h0) begin fail_cnt++; $display("FAIL mid_s_addr: got %h expected 0", bus.s_addr); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.s_ready[4] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) bus.s_ready = '0;
      if (bus.done) dones++;
      if ((bus.s_rstrb != '0) || (bus.s_wstrb != '0)) strobes++;
    end
    check_cnt++; if (dones !== 0) begin fail_cnt++; $display("FAIL mid_late_done: got %0d expected 0", dones); end
    check_cnt++; if (strobes !== 0) begin fail_cnt++; $display("FAIL mid_late_strobe: got %0d expected 0", strobes); end
    txn(32'hF000_0000, 32'h0, 4'h0, 1'b1, -1, -1, '0);
    check_cnt++; if (obs.rd !== 32'h0) begin fail_cnt++; $display("FAIL mid_status: got %h expected 0", obs.rd); end
  endtask

  initial begin
    base_tab[0] = 16'h0000; base_tab[1] = 16'hA000; base_tab[2] = 16'h1000; base_tab[3] = 16'h2000;
    base_tab[4] = 16'h3000; base_tab[5] = 16'h4000; base_tab[6] = 16'h0500; base_tab[7] = 16'h0600;
    drive_idle();
    bus.s_ready = '0;
    load_slave_data();
    test_reset();
    test_read_zero_wait();
    test_write();
    test_unmapped();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end
endmodule
